// File: rtl/fifo_stream_reader.sv
// Read-side controller for the receive sync_fifo: 2-entry skid buffer over a registered-read port
// plus forward-skip servicing. Define FIFO_READER_COUNT_EN to add the word_count output.
module fifo_stream_reader #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_jump,
  output logic [ADDR_WIDTH-1:0] fifo_jump_value,
  input  logic                  fifo_jump_error,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  skip_req,
  input  logic [ADDR_WIDTH-1:0] skip_count,
  output logic                  skip_busy,
  output logic                  skip_done,
`ifdef FIFO_READER_COUNT_EN
  output logic                  skip_err,
  output logic [15:0]           word_count
`else
  output logic                  skip_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_JUMP, S_DONE, S_ERR} state_t;

  state_t                  state, state_nx;
  logic [1:0]              occ, occ_nx;
  logic                    rd_vld_p1;
  logic [DATA_WIDTH-1:0]   buf0, buf1, buf0_nx, buf1_nx;
  logic [ADDR_WIDTH-1:0]   n_q, n_nx;
  logic [ADDR_WIDTH-1:0]   occ_w;
  logic [2:0]              demand;
  logic                    hs;

  assign occ_w   = ADDR_WIDTH'(occ);
  assign m_valid = (state == S_IDLE) && (occ != 2'd0);
  assign m_data  = buf0;
  assign hs      = m_valid && m_ready;
  // Slots already claimed once this cycle's handshake retires; keeps the buffer from overflowing.
  assign demand  = 3'(occ) + 3'(rd_vld_p1) - 3'(hs);

  assign fifo_rd_en = !rst && (state == S_IDLE) && !fifo_empty && (demand < 3'd2);
  assign skip_busy  = (state != S_IDLE);

  always_comb begin
    state_nx        = state;
    n_nx            = n_q;
    occ_nx          = occ;
    buf0_nx         = buf0;
    buf1_nx         = buf1;
    fifo_jump       = 1'b0;
    fifo_jump_value = '0;
    skip_done       = 1'b0;
    skip_err        = 1'b0;

    if (hs) begin
      buf0_nx = buf1;
      occ_nx  = occ - 2'd1;
    end
    if (rd_vld_p1) begin
      if (occ_nx == 2'd0) buf0_nx = fifo_rd_data;
      else                buf1_nx = fifo_rd_data;
      occ_nx = occ_nx + 2'd1;
    end

    case (state)
      S_IDLE: begin
        if (skip_req) begin
          n_nx     = skip_count;
          state_nx = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Wait out a landing word so the buffered count is final before deciding.
        if (!rd_vld_p1) begin
          if (n_q == '0) begin
            state_nx = S_DONE;
          end else if (n_q <= occ_w) begin
            if (n_q == ADDR_WIDTH'(1)) begin
              buf0_nx = buf1;
              occ_nx  = occ - 2'd1;
            end else begin
              occ_nx = 2'd0;
            end
            state_nx = S_DONE;
          end else begin
            state_nx = S_JUMP;
          end
        end
      end
      S_JUMP: begin
        fifo_jump       = 1'b1;
        fifo_jump_value = n_q - occ_w;
        if (fifo_jump_error) begin
          state_nx = S_ERR;
        end else begin
          occ_nx   = 2'd0;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        skip_done = 1'b1;
        state_nx  = S_IDLE;
      end
      S_ERR: begin
        skip_err = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // p0 -> p1: pop issued, read data lands one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      occ       <= 2'd0;
      rd_vld_p1 <= 1'b0;
      n_q       <= '0;
    end else begin
      state     <= state_nx;
      occ       <= occ_nx;
      rd_vld_p1 <= fifo_rd_en && !fifo_empty;
      n_q       <= n_nx;
    end
  end

  // Head entry is cleared so m_data reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) buf0 <= '0;
    else     buf0 <= buf0_nx;
    buf1 <= buf1_nx;
  end

`ifdef FIFO_READER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                   word_count <= 16'd0;
    else if (state == S_DONE)  word_count <= word_count + 16'(n_q);
    else if (hs)               word_count <= word_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural sync_fifo model plus an output scoreboard.
module tb_fifo_stream_reader;
  localparam int AW = 3;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty;
  logic          fifo_jump;
  logic [AW-1:0] fifo_jump_value;
  logic          fifo_jump_error;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          skip_req;
  logic [AW-1:0] skip_count;
  logic          skip_busy;
  logic          skip_done;
  logic          skip_err;
`ifdef FIFO_READER_COUNT_EN
  logic [15:0]   word_count;
  int            exp_wc = 0;
`endif

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fq[$];
  int            fcnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  int            pass_cnt = 0;
  int            chk_cnt = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_jump(fifo_jump), .fifo_jump_value(fifo_jump_value), .fifo_jump_error(fifo_jump_error),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .skip_req(skip_req), .skip_count(skip_count), .skip_busy(skip_busy),
    .skip_done(skip_done),
`ifdef FIFO_READER_COUNT_EN
    .skip_err(skip_err), .word_count(word_count)
`else
    .skip_err(skip_err)
`endif
  );

  // sync_fifo model: registered read data, registered write pointer, jump rejected at/after wptr
  assign fifo_empty      = (fcnt == 0);
  assign fifo_jump_error = fifo_jump && (int'(fifo_jump_value) >= fcnt);

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fcnt <= 0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (fifo_jump && !fifo_jump_error)
        for (int k = 0; k < int'(fifo_jump_value); k++) fq.delete(0);
      if (wr_en) fq.push_back(wr_data);
      fcnt <= fq.size();
    end
  end

  // Scoreboard: every accepted word must match the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_extra: got %h expected no word", m_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (m_data !== mon_exp) $display("FAIL stream_data: got %h expected %h", m_data, mon_exp);
          else pass_cnt++;
        end
`ifdef FIFO_READER_COUNT_EN
        exp_wc++;
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_data = base + DW'(i);
      exp_q.push_back(base + DW'(i));
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_skip(input logic [AW-1:0] n, output logic done, output logic err,
                          output logic jumped, output logic [AW-1:0] jv, output int dur,
                          output logic busy1);
    done = 0; err = 0; jumped = 0; jv = '0; dur = 0; busy1 = 0;
    @(posedge clk); #1;
    skip_req = 1'b1;
    skip_count = n;
    @(posedge clk); #1;
    skip_req = 1'b0;
    for (int c = 1; c <= 10 && !done && !err; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = skip_busy;
      if (fifo_jump) begin jumped = 1; jv = fifo_jump_value; end
      if (skip_done) done = 1;
      if (skip_err) err = 1;
      dur = c + 1;
    end
  endtask

  task automatic drain_wait();
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; wr_data = '0; m_ready = 0; skip_req = 0; skip_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b expected 0", fifo_rd_en); else pass_cnt++;
    chk_cnt++; if (fifo_jump !== 1'b0) $display("FAIL rst_jump: got %b expected 0", fifo_jump); else pass_cnt++;
    chk_cnt++; if (fifo_jump_value !== '0) $display("FAIL rst_jump_value: got %0d expected 0", fifo_jump_value); else pass_cnt++;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", m_valid); else pass_cnt++;
    chk_cnt++; if (m_data !== '0) $display("FAIL rst_m_data: got %h expected 0", m_data); else pass_cnt++;
    chk_cnt++; if (skip_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", skip_busy); else pass_cnt++;
    chk_cnt++; if (skip_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", skip_done); else pass_cnt++;
    chk_cnt++; if (skip_err !== 1'b0) $display("FAIL rst_err: got %b expected 0", skip_err); else pass_cnt++;
`ifdef FIFO_READER_COUNT_EN
    chk_cnt++; if (word_count !== 16'd0) $display("FAIL rst_word_count: got %0d expected 0", word_count); else pass_cnt++;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    int first_rd = -1, first_vld = -1, last_vld = -1, nvld = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c < 5) begin
        wr_en = 1'b1; wr_data = DW'(c + 1); exp_q.push_back(DW'(c + 1));
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (m_valid) begin
        if (first_vld < 0) first_vld = c;
        last_vld = c;
        nvld++;
      end
    end
    chk_cnt++; if (first_vld - first_rd !== 2) $display("FAIL stream_latency: got %0d expected 2", first_vld - first_rd); else pass_cnt++;
    chk_cnt++; if (last_vld - first_vld + 1 !== 5) $display("FAIL stream_gapless: got span %0d expected 5", last_vld - first_vld + 1); else pass_cnt++;
    chk_cnt++; if (nvld !== 5) $display("FAIL stream_count: got %0d expected 5", nvld); else pass_cnt++;
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL stream_drained: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int changes = 0;
    m_ready = 1'b0;
    write_words(6, 24'h000011);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_data !== 24'h000011) changes++;
    end
    chk_cnt++; if (changes !== 0) $display("FAIL bp_stable: got %0d changed cycles expected 0", changes); else pass_cnt++;
    chk_cnt++; if (m_valid !== 1'b1) $display("FAIL bp_valid: got %b expected 1", m_valid); else pass_cnt++;
    chk_cnt++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en: got %b expected 0", fifo_rd_en); else pass_cnt++;
    chk_cnt++; if (fcnt !== 4) $display("FAIL bp_fifo_left: got %0d expected 4", fcnt); else pass_cnt++;
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain_wait();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL bp_drained: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_skip_buffer();
    logic done, err, jumped, busy1, seen;
    logic [AW-1:0] jv;
    int dur;
    m_ready = 1'b0;
    write_words(6, 24'h000021);
    idle(8);
    run_skip(3'd2, done, err, jumped, jv, dur, busy1);
    chk_cnt++; if (busy1 !== 1'b1) $display("FAIL sb_busy: got %b expected 1", busy1); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL sb_done: got done=%b err=%b expected done=1 err=0", done, err); else pass_cnt++;
    chk_cnt++; if (jumped !== 1'b0) $display("FAIL sb_no_jump: got %b expected 0", jumped); else pass_cnt++;
    chk_cnt++; if (dur !== 3) $display("FAIL sb_cycles: got %0d expected 3", dur); else pass_cnt++;
    if (done) begin
      void'(exp_q.pop_front()); void'(exp_q.pop_front());
`ifdef FIFO_READER_COUNT_EN
      exp_wc += 2;
`endif
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk_cnt++; if (m_data !== 24'h000023) $display("FAIL sb_next_word: got %h expected 000023", m_data); else pass_cnt++;
    drain_wait();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL sb_drained: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_fifo_jump();
    logic done, err, jumped, busy1, seen;
    logic [AW-1:0] jv;
    int dur;
    m_ready = 1'b0;
    write_words(8, 24'h000031);
    idle(8);
    run_skip(3'd5, done, err, jumped, jv, dur, busy1);
    chk_cnt++; if (jumped !== 1'b1 || jv !== 3'd3) $display("FAIL fj_jump: got jump=%b value=%0d expected jump=1 value=3", jumped, jv); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1 || err !== 1'b0) $display("FAIL fj_done: got done=%b err=%b expected done=1 err=0", done, err); else pass_cnt++;
    chk_cnt++; if (dur !== 4) $display("FAIL fj_cycles: got %0d expected 4", dur); else pass_cnt++;
    if (done) begin
      for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
`ifdef FIFO_READER_COUNT_EN
      exp_wc += 5;
`endif
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk_cnt++; if (m_data !== 24'h000036) $display("FAIL fj_next_word: got %h expected 000036", m_data); else pass_cnt++;
    drain_wait();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL fj_drained: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_rejected_skip();
    logic done, err, jumped, busy1, seen;
    logic [AW-1:0] jv;
    int dur;
    m_ready = 1'b0;
    write_words(4, 24'h000041);
    idle(8);
    run_skip(3'd4, done, err, jumped, jv, dur, busy1);
    chk_cnt++; if (jumped !== 1'b1 || jv !== 3'd2) $display("FAIL rj_jump: got jump=%b value=%0d expected jump=1 value=2", jumped, jv); else pass_cnt++;
    chk_cnt++; if (err !== 1'b1 || done !== 1'b0) $display("FAIL rj_err: got err=%b done=%b expected err=1 done=0", err, done); else pass_cnt++;
    chk_cnt++; if (dur !== 4) $display("FAIL rj_cycles: got %0d expected 4", dur); else pass_cnt++;
    @(posedge clk); #1;
    m_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk_cnt++; if (m_data !== 24'h000041) $display("FAIL rj_resume_word: got %h expected 000041", m_data); else pass_cnt++;
    drain_wait();
    chk_cnt++; if (exp_q.size() !== 0) $display("FAIL rj_drained: got %0d left expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_in_jump();
    logic seen = 0;
    int pulses = 0;
    m_ready = 1'b0;
    write_words(8, 24'h000051);
    idle(8);
`ifdef FIFO_READER_COUNT_EN
    chk_cnt++; if (word_count !== 16'(exp_wc)) $display("FAIL wc_total: got %0d expected %0d", word_count, exp_wc); else pass_cnt++;
`endif
    skip_req = 1'b1; skip_count = 3'd5;
    @(posedge clk); #1;
    skip_req = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (fifo_jump) seen = 1;
    end
    chk_cnt++; if (seen !== 1'b1) $display("FAIL rjmp_reached: got %b expected 1", seen); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (fifo_jump !== 1'b0 || fifo_jump_value !== '0) $display("FAIL rjmp_jump: got %b/%0d expected 0/0", fifo_jump, fifo_jump_value); else pass_cnt++;
    chk_cnt++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) $display("FAIL rjmp_stream: got rd_en=%b m_valid=%b expected 0/0", fifo_rd_en, m_valid); else pass_cnt++;
    chk_cnt++; if (skip_busy !== 1'b0 || skip_done !== 1'b0 || skip_err !== 1'b0) $display("FAIL rjmp_skip: got busy=%b done=%b err=%b expected 0/0/0", skip_busy, skip_done, skip_err); else pass_cnt++;
    chk_cnt++; if (m_data !== '0) $display("FAIL rjmp_m_data: got %h expected 0", m_data); else pass_cnt++;
`ifdef FIFO_READER_COUNT_EN
    chk_cnt++; if (word_count !== 16'd0) $display("FAIL rjmp_word_count: got %0d expected 0", word_count); else pass_cnt++;
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (skip_done || skip_err) pulses++;
    end
    chk_cnt++; if (pulses !== 0) $display("FAIL rjmp_no_pulse: got %0d pulses expected 0", pulses); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_skip_buffer();
    test_fifo_jump();
    test_rejected_skip();
    test_reset_in_jump();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
